id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-delivery stage directly upstream of the ALU.
//  Captures decoded fields, then drives ALU in_a/in_b/alu_control in EX with forwarded operands.
//  Detects load-use hazards, stalls ID and inserts bubbles. Applies branch flush.
// PARAMETERS
//  XLEN   32  datapath width
//  RA_W   5   register index width
// PORTS
//  clk            in   1     rising-edge clock (single clock domain)
//  rst            in   1     synchronous reset, active-high
//  id_valid       in   1     ID holds a valid instruction
//  id_ready       out  1     0 = stall IF/ID this cycle
//  flush          in   1     taken branch/jump resolved in EX; kill younger instructions
//  id_pc          in   XLEN  instruction PC
//  id_rs1_data    in   XLEN  register file read port 1
//  id_rs2_data    in   XLEN  register file read port 2
//  id_imm         in   XLEN  immediate; U-type carries imm[31:12] right-aligned (ALU shifts)
//  id_rs1/id_rs2  in   RA_W  source indices
//  id_use_rs1/2   in   1     instruction actually reads rs1/rs2
//  id_rd          in   RA_W  destination index
//  id_alu_control in   4     ALU op code (0000 ADD ... 1100 AUIPC, 1111 LUI)
//  id_alu_src_a   in   2     00 rs1, 01 pc, 10 zero
//  id_alu_src_b   in   1     0 rs2, 1 imm
//  id_reg_write, id_mem_read, id_mem_write  in 1  control bits
//  mem_rd/mem_reg_write/mem_result  in RA_W/1/XLEN  EX/MEM producer
//  wb_rd/wb_reg_write/wb_result     in RA_W/1/XLEN  MEM/WB producer
//  ex_valid       out  1     EX slot valid
//  ex_in_a/ex_in_b out XLEN  ALU operands
//  ex_alu_control out  4     ALU op; 4'b1110 (result 0) when !ex_valid
//  ex_store_data  out  XLEN  forwarded rs2 for stores
//  ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write  out  registered copies, gated by ex_valid
// BEHAVIOUR
//  - Reset: all EX registers 0, ex_valid=0, ex_alu_control=4'b1110; id_ready=1 next cycle.
//  - Latency 1: ID fields captured on clk when id_ready & id_valid; ALU operands valid same cycle in EX.
//  - Load-use: ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
//    -> id_ready=0, next EX slot is a bubble (ex_valid=0, all control bits 0); ID re-presented next cycle.
//  - flush has priority over stall: id_ready=1, next ex_valid=0; same-cycle ID instruction dropped.
//  - id_valid=0 with id_ready=1 -> bubble loaded.
//  - Forward (EX, combinational on registered rs indices): EX/MEM beats MEM/WB; index 0 never forwarded;
//    requires producer reg_write=1. Applies to rs1 operand, rs2 operand and ex_store_data.
//  - Operand mux after forwarding: src_a pc/zero bypass forwarding; src_b=1 selects imm, store data still rs2.
//  - No arithmetic here; widths pass through unmodified.
//  - rst mid-stall: stall released, pending bubble discarded.
// CONFIGURATION
//  EX_FWD_EN defined: forwarding paths as above; only load-use stalls (1 bubble).
//  EX_FWD_EN undefined: no forwarding; id_ready=0 while any used rs matches nonzero rd with reg_write in EX or
//    EX/MEM stage (ex_* and mem_*); WB hazards resolved by register file write-through.
// STRUCTURE
//  Shared package rv_core_pkg: ALU op codes (ALU_ADD..ALU_LUI, ALU_NOP=4'b1110), src_a/src_b select codes, XLEN.
//  Sub-module fwd_unit: rs indices + mem/wb producers -> 2-bit select per operand; instanced twice.
// TESTING
//  1 rst held 2 cycles -> ex_valid=0, ex_alu_control=4'b1110, id_ready=1.
//  2 ADD x3,x1,x2 then SUB x4,x3,x1 (x1=5,x2=7) -> EX/MEM forward, SUB ex_in_a=12, no stall.
//  3 LW x5 then ADD x6,x5,x0 -> id_ready=0 one cycle, one bubble, ADD gets wb_result via MEM/WB forward.
//  4 flush and load-use in same cycle -> id_ready=1, next ex_valid=0, no extra bubble after.
//  5 ADDI x0,x0,9 then ADD x7,x0,x0 -> ex_in_a=0 (x0 not forwarded); LUI imm=20'hABCDE -> ex_in_b=32'h000ABCDE.
//  6 EX_FWD_EN undefined, scenario 2 -> two stall cycles, SUB ex_in_a=12 from register file.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core definitions: widths, ALU op codes, operand-select and forward-select codes.
// Used by id_ex_stage (optional feature macro: EX_FWD_EN) and its fwd_unit.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_AUIPC = 4'b1100,
    ALU_NOP   = 4'b1110,
    ALU_LUI   = 4'b1111
  } alu_op_e;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic       SRC_B_RS2  = 1'b0;
  localparam logic       SRC_B_IMM  = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [3:0]      alu_control;
    logic [1:0]      src_a;
    logic            src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_regs_t;

  // A used source register collides with a live, nonzero producer destination.
  function automatic logic rs_hit(input logic use_rs, input logic [RA_W-1:0] rs,
                                  input logic [RA_W-1:0] rd, input logic we);
    return use_rs & we & (rd != '0) & (rs == rd);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side fields, downstream producers and the EX-side ALU operands.
// master = decode/pipeline side driving ID fields; slave = the id_ex_stage itself.
interface id_ex_stage_if;
  import rv_core_pkg::*;

  logic            id_valid;
  logic            id_ready;
  logic            flush;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [RA_W-1:0] id_rd;
  logic [3:0]      id_alu_control;
  logic [1:0]      id_alu_src_a;
  logic            id_alu_src_b;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic [RA_W-1:0] mem_rd;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [RA_W-1:0] wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] ex_in_a;
  logic [XLEN-1:0] ex_in_b;
  logic [3:0]      ex_alu_control;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;

  modport master (
    output id_valid, flush, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_alu_control, id_alu_src_a, id_alu_src_b,
           id_reg_write, id_mem_read, id_mem_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, flush, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_alu_control, id_alu_src_a, id_alu_src_b,
           id_reg_write, id_mem_read, id_mem_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

endinterface

// File: rtl/fwd_unit.sv
// Per-operand forward select: EX/MEM producer wins over MEM/WB; x0 is never forwarded.
module fwd_unit
  import rv_core_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs_hit(1'b1, rs, mem_rd, mem_reg_write)) begin
      sel = FWD_MEM;
    end else if (rs_hit(1'b1, rs, wb_rd, wb_reg_write)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall, flush and forwarded ALU operand delivery.
// Define EX_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall until WB.
module id_ex_stage
  import rv_core_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ex_regs_t        ex_reg;
  ex_regs_t        ex_next;
  logic            hazard;
  logic            stall;
  logic [RA_W-1:0] ex_rs      [2];
  logic [XLEN-1:0] ex_rs_data [2];
  logic [1:0]      fwd_sel    [2];
  logic [XLEN-1:0] rs_fwd     [2];
  logic [XLEN-1:0] in_a;

`ifdef EX_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = ex_reg.valid & ex_reg.mem_read &
                  (rs_hit(bus.id_use_rs1, bus.id_rs1, ex_reg.rd, 1'b1) |
                   rs_hit(bus.id_use_rs2, bus.id_rs2, ex_reg.rd, 1'b1));
`else
  assign hazard = rs_hit(bus.id_use_rs1, bus.id_rs1, ex_reg.rd, ex_reg.valid & ex_reg.reg_write) |
                  rs_hit(bus.id_use_rs2, bus.id_rs2, ex_reg.rd, ex_reg.valid & ex_reg.reg_write) |
                  rs_hit(bus.id_use_rs1, bus.id_rs1, bus.mem_rd, bus.mem_reg_write) |
                  rs_hit(bus.id_use_rs2, bus.id_rs2, bus.mem_rd, bus.mem_reg_write);
`endif

  assign stall       = hazard & ~bus.flush;
  assign bus.id_ready = ~stall;

  // Flush, stall and an empty ID all load an all-zero bubble.
  always_comb begin
    ex_next = '0;
    if (!bus.flush && !stall && bus.id_valid) begin
      ex_next.valid       = 1'b1;
      ex_next.pc          = bus.id_pc;
      ex_next.rs1_data    = bus.id_rs1_data;
      ex_next.rs2_data    = bus.id_rs2_data;
      ex_next.imm         = bus.id_imm;
      ex_next.rs1         = bus.id_rs1;
      ex_next.rs2         = bus.id_rs2;
      ex_next.rd          = bus.id_rd;
      ex_next.alu_control = bus.id_alu_control;
      ex_next.src_a       = bus.id_alu_src_a;
      ex_next.src_b       = bus.id_alu_src_b;
      ex_next.reg_write   = bus.id_reg_write;
      ex_next.mem_read    = bus.id_mem_read;
      ex_next.mem_write   = bus.id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg <= '0;
    end else begin
      ex_reg <= ex_next;
    end
  end

  assign ex_rs[0]      = ex_reg.rs1;
  assign ex_rs[1]      = ex_reg.rs2;
  assign ex_rs_data[0] = ex_reg.rs1_data;
  assign ex_rs_data[1] = ex_reg.rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef EX_FWD_EN
    fwd_unit u_fwd (
      .rs            (ex_rs[gi]),
      .mem_rd        (bus.mem_rd),
      .mem_reg_write (bus.mem_reg_write),
      .wb_rd         (bus.wb_rd),
      .wb_reg_write  (bus.wb_reg_write),
      .sel           (fwd_sel[gi])
    );
`else
    assign fwd_sel[gi] = FWD_RF;
`endif
    assign rs_fwd[gi] = (fwd_sel[gi] == FWD_MEM) ? bus.mem_result :
                        (fwd_sel[gi] == FWD_WB)  ? bus.wb_result  : ex_rs_data[gi];
  end

  always_comb begin
    case (ex_reg.src_a)
      SRC_A_RS1: in_a = rs_fwd[0];
      SRC_A_PC:  in_a = ex_reg.pc;
      default:   in_a = '0;
    endcase
  end

  assign bus.ex_valid       = ex_reg.valid;
  assign bus.ex_in_a        = in_a;
  assign bus.ex_in_b        = (ex_reg.src_b == SRC_B_IMM) ? ex_reg.imm : rs_fwd[1];
  assign bus.ex_store_data  = rs_fwd[1];
  assign bus.ex_alu_control = ex_reg.valid ? ex_reg.alu_control : ALU_NOP;
  assign bus.ex_pc          = ex_reg.valid ? ex_reg.pc : '0;
  assign bus.ex_rd          = ex_reg.valid ? ex_reg.rd : '0;
  assign bus.ex_reg_write   = ex_reg.valid & ex_reg.reg_write;
  assign bus.ex_mem_read    = ex_reg.valid & ex_reg.mem_read;
  assign bus.ex_mem_write   = ex_reg.valid & ex_reg.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations follow the EX_FWD_EN setting of the build.
module tb_id_ex_stage;
  import rv_core_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [3:0] ctl, input logic [1:0] sa, input logic sb,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid = 1'b1;       bus.id_pc = pc;
    bus.id_rs1 = rs1;          bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1;       bus.id_use_rs2 = u2;
    bus.id_rd = rd;            bus.id_rs1_data = d1;
    bus.id_rs2_data = d2;      bus.id_imm = imm;
    bus.id_alu_control = ctl;  bus.id_alu_src_a = sa;
    bus.id_alu_src_b = sb;     bus.id_reg_write = rw;
    bus.id_mem_read = mr;      bus.id_mem_write = mw;
  endtask

  task automatic idle_id();
    drive_id('0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    bus.mem_rd = rd; bus.mem_reg_write = rw; bus.mem_result = res;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    bus.wb_rd = rd; bus.wb_reg_write = rw; bus.wb_result = res;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.flush = 1'b0; idle_id(); set_mem('0, 1'b0, '0); set_wb('0, 1'b0, '0);
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid: got %b want 0", bus.ex_valid); end
    n_vec++; if (bus.ex_alu_control !== 4'b1110) begin n_err++; $display("FAIL rst_alu: got %b want 1110", bus.ex_alu_control); end
    n_vec++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL rst_id_ready: got %b want 1", bus.id_ready); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0) begin n_err++; $display("FAIL idle_bubble: got valid=%b pc=%h want 0/0", bus.ex_valid, bus.ex_pc); end
    $display("test_reset: done");
  endtask

`ifdef EX_FWD_EN
  task automatic test_fwd_exmem();
    drive_id(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 32'd5, 32'd7, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_vec++; if (bus.ex_in_a !== 32'd5 || bus.ex_in_b !== 32'd7) begin n_err++; $display("FAIL add_ops: got %h/%h want 5/7", bus.ex_in_a, bus.ex_in_b); end
    drive_id(32'h104, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 32'hBAD0BAD0, 32'd5, '0, ALU_SUB, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL sub_no_stall: got %b want 1", bus.id_ready); end
    @(negedge clk);
    idle_id(); set_mem(5'd3, 1'b1, 32'd12); set_wb(5'd3, 1'b1, 32'd99);
    #1;
    n_vec++; if (bus.ex_in_a !== 32'd12) begin n_err++; $display("FAIL sub_fwd_a: got %h want %h", bus.ex_in_a, 32'd12); end
    n_vec++; if (bus.ex_in_b !== 32'd5 || bus.ex_alu_control !== 4'b0001) begin n_err++; $display("FAIL sub_b_alu: got %h/%b want 5/0001", bus.ex_in_b, bus.ex_alu_control); end
    @(negedge clk); set_mem('0, 1'b0, '0); set_wb('0, 1'b0, '0);
    $display("test_fwd_exmem: done");
  endtask

  task automatic test_load_use();
    drive_id(32'h200, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h1000, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive_id(32'h204, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 32'hBAD0BAD0, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall: got %b want 0", bus.id_ready); end
    @(negedge clk);
    set_mem(5'd5, 1'b1, 32'h1000);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got v=%b rw=%b want 0/0", bus.ex_valid, bus.ex_reg_write); end
    n_vec++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", bus.id_ready); end
    @(negedge clk);
    idle_id(); set_mem(5'd5, 1'b0, 32'h1000); set_wb(5'd5, 1'b1, 32'h0000CAFE);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin n_err++; $display("FAIL lu_add_issue: got v=%b rd=%0d want 1/6", bus.ex_valid, bus.ex_rd); end
    n_vec++; if (bus.ex_in_a !== 32'h0000CAFE) begin n_err++; $display("FAIL lu_wb_fwd: got %h want 0000cafe", bus.ex_in_a); end
    @(negedge clk); set_mem('0, 1'b0, '0); set_wb('0, 1'b0, '0);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_single_bubble: got %b want 0", bus.ex_valid); end
    $display("test_load_use: done");
  endtask

  task automatic test_store_fwd();
    drive_id(32'h500, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 32'h2000, 32'hBAD0BAD0, 32'd8, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle_id(); set_mem(5'd3, 1'b1, 32'h55); set_wb(5'd3, 1'b1, 32'h66);
    #1;
    n_vec++; if (bus.ex_store_data !== 32'h55) begin n_err++; $display("FAIL st_data_fwd: got %h want 55", bus.ex_store_data); end
    n_vec++; if (bus.ex_in_b !== 32'd8 || bus.ex_in_a !== 32'h2000) begin n_err++; $display("FAIL st_ops: got %h/%h want 2000/8", bus.ex_in_a, bus.ex_in_b); end
    n_vec++; if (bus.ex_mem_write !== 1'b1 || bus.ex_reg_write !== 1'b0) begin n_err++; $display("FAIL st_ctl: got mw=%b rw=%b want 1/0", bus.ex_mem_write, bus.ex_reg_write); end
    @(negedge clk); set_mem('0, 1'b0, '0); set_wb('0, 1'b0, '0);
    $display("test_store_fwd: done");
  endtask
`else
  task automatic test_no_fwd();
    drive_id(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 32'd5, 32'd7, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_vec++; if (bus.ex_in_a !== 32'd5 || bus.ex_in_b !== 32'd7) begin n_err++; $display("FAIL add_ops: got %h/%h want 5/7", bus.ex_in_a, bus.ex_in_b); end
    drive_id(32'h104, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 32'hBAD0BAD0, 32'd5, '0, ALU_SUB, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL nf_stall_ex: got %b want 0", bus.id_ready); end
    @(negedge clk);
    set_mem(5'd3, 1'b1, 32'd12);
    #1;
    n_vec++; if (bus.id_ready !== 1'b0 || bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL nf_stall_mem: got rdy=%b v=%b want 0/0", bus.id_ready, bus.ex_valid); end
    @(negedge clk);
    set_mem('0, 1'b0, '0); set_wb(5'd3, 1'b1, 32'd12); bus.id_rs1_data = 32'd12;
    #1;
    n_vec++; if (bus.id_ready !== 1'b1 || bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL nf_release: got rdy=%b v=%b want 1/0", bus.id_ready, bus.ex_valid); end
    @(negedge clk);
    idle_id(); set_wb('0, 1'b0, '0);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_in_a !== 32'd12) begin n_err++; $display("FAIL nf_sub_a: got v=%b a=%h want 1/0000000c", bus.ex_valid, bus.ex_in_a); end
    n_vec++; if (bus.ex_alu_control !== 4'b0001) begin n_err++; $display("FAIL nf_sub_alu: got %b want 0001", bus.ex_alu_control); end
    @(negedge clk);
    $display("test_no_fwd: done");
  endtask
`endif

  task automatic test_flush();
    drive_id(32'h200, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h1000, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive_id(32'h204, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, '0, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    n_vec++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %b want 1", bus.id_ready); end
    @(negedge clk);
    bus.flush = 1'b0; set_mem(5'd5, 1'b1, 32'h1000);
    drive_id(32'h300, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 32'd3, 32'd4, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b0 || bus.id_ready !== 1'b1) begin n_err++; $display("FAIL fl_killed: got v=%b rdy=%b want 0/1", bus.ex_valid, bus.id_ready); end
    @(negedge clk);
    idle_id(); set_mem('0, 1'b0, '0);
    #1;
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8 || bus.ex_in_a !== 32'd3) begin n_err++; $display("FAIL fl_target: got v=%b rd=%0d a=%h want 1/8/3", bus.ex_valid, bus.ex_rd, bus.ex_in_a); end
    @(negedge clk);
    $display("test_flush: done");
  endtask

  task automatic test_x0_lui();
    drive_id(32'h300, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0, '0, 32'd9, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_id(32'h304, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, '0, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.ex_in_b !== 32'd9 || bus.id_ready !== 1'b1) begin n_err++; $display("FAIL addi_imm: got b=%h rdy=%b want 9/1", bus.ex_in_b, bus.id_ready); end
    @(negedge clk);
    set_mem(5'd0, 1'b1, 32'd9); set_wb(5'd0, 1'b1, 32'd5);
    drive_id(32'h308, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, '0, '0, 32'h000ABCDE, ALU_LUI, SRC_A_ZERO, SRC_B_IMM, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.ex_in_a !== 32'h0 || bus.ex_in_b !== 32'h0) begin n_err++; $display("FAIL x0_no_fwd: got %h/%h want 0/0", bus.ex_in_a, bus.ex_in_b); end
    @(negedge clk);
    set_mem('0, 1'b0, '0); set_wb('0, 1'b0, '0);
    drive_id(32'h40C, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 32'hFFFF0000, '0, 32'h00012345, ALU_AUIPC, SRC_A_PC, SRC_B_IMM, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.ex_in_b !== 32'h000ABCDE || bus.ex_in_a !== 32'h0) begin n_err++; $display("FAIL lui_ops: got %h/%h want 0/000abcde", bus.ex_in_a, bus.ex_in_b); end
    n_vec++; if (bus.ex_alu_control !== 4'b1111) begin n_err++; $display("FAIL lui_alu: got %b want 1111", bus.ex_alu_control); end
    @(negedge clk);
    idle_id();
    #1;
    n_vec++; if (bus.ex_in_a !== 32'h40C || bus.ex_pc !== 32'h40C) begin n_err++; $display("FAIL auipc_pc: got a=%h pc=%h want 40c/40c", bus.ex_in_a, bus.ex_pc); end
    n_vec++; if (bus.ex_in_b !== 32'h00012345 || bus.ex_alu_control !== 4'b1100) begin n_err++; $display("FAIL auipc_b_alu: got %h/%b want 00012345/1100", bus.ex_in_b, bus.ex_alu_control); end
    @(negedge clk);
    $display("test_x0_lui: done");
  endtask

  task automatic test_rst_mid_stall();
    drive_id(32'h600, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h1000, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive_id(32'h604, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, '0, '0, '0, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL rs_stall: got %b want 0", bus.id_ready); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (bus.id_ready !== 1'b1 || bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL rs_released: got rdy=%b v=%b want 1/0", bus.id_ready, bus.ex_valid); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin n_err++; $display("FAIL rs_reissue: got v=%b rd=%0d want 1/6", bus.ex_valid, bus.ex_rd); end
    idle_id();
    @(negedge clk);
    $display("test_rst_mid_stall: done");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
`ifdef EX_FWD_EN
    test_fwd_exmem();
    test_load_use();
    test_store_fwd();
`else
    test_no_fwd();
`endif
    test_flush();
    test_x0_lui();
    test_rst_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
